mult_seq_ctrl: RTL

Sequencer for the bit-serial neuron multiplier (Mult).
- Accepts one neuron/weight operand pair through a valid/ready handshake and clears the multiplier.
- Streams the weight into Mult one bit per cycle, MSB first, while holding the neuron value stable.
- Waits a drain interval, captures Mult's product and presents it through a valid/ready result handshake.
- Sits between the layer scheduler and one Mult instance; drives all Mult control inputs except its own clock.

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/mult_seq_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and default widths for the bit-serial multiplier sequencer.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned WEIGHT_W_DEF = 16;

endpackage

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the bit-serial neuron multiplier: accepts an operand pair, streams the weight MSB first,
// captures the product. Optional busy-cycle counter enabled by defining MULT_SEQ_PERF_EN.
module mult_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned WEIGHT_W  = WEIGHT_W_DEF,
    parameter int unsigned DRAIN_CYC = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   neuron_in,
    input  logic [WEIGHT_W-1:0] weight_in,
    output logic                mult_clear,
    output logic                mult_enable,
    output logic                mult_weight_bit,
    output logic [DATA_W-1:0]   mult_input_neuron,
    input  logic [DATA_W-1:0]   mult_out,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    input  logic                result_ready
`ifdef MULT_SEQ_PERF_EN
    ,
    output logic [31:0]         perf_busy_cnt
`endif
);

    localparam int unsigned CNT_W   = $clog2(WEIGHT_W) + 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [WEIGHT_W-1:0] weight_reg;

    // Outputs are registered alongside the state: each transition loads the values the next state presents.
    // The weight is shifted left so its MSB is always the next bit to stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            in_ready          <= 1'b1;
            bit_cnt           <= '0;
            drain_cnt         <= '0;
            weight_reg        <= '0;
            mult_clear        <= 1'b0;
            mult_enable       <= 1'b0;
            mult_weight_bit   <= 1'b0;
            mult_input_neuron <= '0;
            result            <= '0;
            result_valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mult_input_neuron <= neuron_in;
                        weight_reg        <= weight_in;
                        in_ready          <= 1'b0;
                        mult_clear        <= 1'b1;
                        state             <= CLEAR;
                    end
                end
                CLEAR: begin
                    mult_clear      <= 1'b0;
                    mult_enable     <= 1'b1;
                    mult_weight_bit <= weight_reg[WEIGHT_W-1];
                    weight_reg      <= weight_reg << 1;
                    bit_cnt         <= '0;
                    state           <= SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt == CNT_W'(WEIGHT_W - 1)) begin
                        mult_enable     <= 1'b0;
                        mult_weight_bit <= 1'b0;
                        drain_cnt       <= '0;
                        state           <= DRAIN;
                    end else begin
                        bit_cnt         <= bit_cnt + CNT_W'(1);
                        mult_weight_bit <= weight_reg[WEIGHT_W-1];
                        weight_reg      <= weight_reg << 1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
                        result       <= mult_out;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef MULT_SEQ_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy_cnt <= '0;
        end else if (state != IDLE && perf_busy_cnt != '1) begin
            perf_busy_cnt <= perf_busy_cnt + 32'd1;
        end
    end
`else
    // No busy-cycle counter in this build.
`endif

endmodule
